// File: rtl/direction_encoder_if.sv
// Handshake bundle between the route planner, the direction encoder and the frame consumer.
interface direction_encoder_if #(
    parameter int DEPTH = 4
);
    logic [2:0]                 dir_in;
    logic                       dir_valid;
    logic                       dir_ready;
    logic [7:0]                 frame_out;
    logic                       frame_valid;
    logic                       frame_ready;
    logic [$clog2(DEPTH):0]     fifo_count;

    modport master (
        output dir_in, dir_valid, frame_ready,
        input  dir_ready, frame_out, frame_valid, fifo_count
    );

    modport slave (
        input  dir_in, dir_valid, frame_ready,
        output dir_ready, frame_out, frame_valid, fifo_count
    );
endinterface

// File: rtl/direction_encoder.sv
// Direction FIFO feeding a 2-state output stage that emits {checker, copy, data} protected frames.
// Optional DIRECTION_ENCODER_ERR_INJECT_EN adds err_inject, which flips data bit 0 of a loaded frame.
module direction_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef DIRECTION_ENCODER_ERR_INJECT_EN
    input  logic                 err_inject,
`endif
    direction_encoder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic { IDLE, SEND } state_t;

    state_t         state;
    logic [2:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [7:0]     frame;
    logic           valid;
    logic           full, empty, push, pop, flip;

`ifdef DIRECTION_ENCODER_ERR_INJECT_EN
    assign flip = err_inject;
`else
    assign flip = 1'b0;
`endif

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // dir_ready follows registered occupancy only, so a same-cycle pop never opens a full FIFO
    assign push  = bus.dir_valid && !full;
    assign pop   = !empty && ((state == IDLE) || bus.frame_ready);

    assign bus.dir_ready   = !full;
    assign bus.frame_out   = frame;
    assign bus.frame_valid = valid;
    assign bus.fifo_count  = count;

    function automatic logic [7:0] encode(input logic [2:0] d, input logic f);
        return {{2{^d}}, d, d ^ {2'b00, f}};
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.dir_in;
    end

    // Pointers are AW bits wide, so wrap from DEPTH-1 to 0 is implicit for power-of-two DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            frame <= 8'h00;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    frame <= encode(mem[rd_ptr], flip);
                    valid <= 1'b1;
                    state <= SEND;
                end
                SEND: if (bus.frame_ready) begin
                    if (!empty) begin
                        frame <= encode(mem[rd_ptr], flip);
                    end else begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
